// File: rtl/serdes_tx_ctrl_if.sv
// Word-side handshake bundle for the SerDes transmit sequencer.
// The master offers a word with s_valid; the slave takes it when s_ready is high.
interface serdes_tx_ctrl_if #(
    parameter int LOGIC_SIZE = 32
);
    logic [LOGIC_SIZE-1:0] s_tdata;
    logic                  s_valid;
    logic                  s_ready;

    modport master (
        output s_tdata,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_tdata,
        input  s_valid,
        output s_ready
    );
endinterface

// File: rtl/serdes_tx_ctrl.sv
// Transmit-side sequencer feeding an 8b/10b encoder.
// Words are framed as SOF, data bytes (LSB first), EOF. Comma characters fill
// idle time and a fixed-length comma train is sent after reset or on request,
// so the receiver can find symbol alignment.
module serdes_tx_ctrl #(
    parameter int LOGIC_SIZE = 32,
    parameter int TRAIN_LEN  = 16,
    parameter int MAX_BURST  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    serdes_tx_ctrl_if.slave        s_axis,
    input  logic                   i_resync,
    output logic [7:0]             o_byte,
    output logic                   o_kin,
    output logic                   o_en,
    output logic                   o_trained
);
    localparam int NBYTES = LOGIC_SIZE / 8;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NBYTES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO   = IDX_W'(0);
    localparam logic [7:0]       TRAIN_LAST = 8'(TRAIN_LEN - 1);
    localparam logic [7:0]       BURST_SAT  = 8'(MAX_BURST);
    localparam logic [8:0]       BURST_LIM  = 9'(MAX_BURST);

    localparam logic [7:0] K_COMMA = 8'hBC;  // K28.5
    localparam logic [7:0] K_SOF   = 8'hFB;  // K27.7
    localparam logic [7:0] K_EOF   = 8'hFD;  // K29.7

    typedef enum logic [2:0] {
        ST_TRAIN = 3'd0,
        ST_IDLE  = 3'd1,
        ST_SOF   = 3'd2,
        ST_DATA  = 3'd3,
        ST_EOF   = 3'd4
    } state_t;

    state_t                state;
    logic [7:0]            train_cnt;
    logic [7:0]            burst_cnt;
    logic                  resync_pend;
    logic [IDX_W-1:0]      idx;
    logic [LOGIC_SIZE-1:0] word;
    logic                  ready;
    logic                  handshake;

    // Select byte i of a word, byte 0 being bits [7:0].
    function automatic logic [7:0] word_byte(input logic [LOGIC_SIZE-1:0] w,
                                             input logic [IDX_W-1:0]      i);
        logic [LOGIC_SIZE-1:0] sh;
        sh = w >> {i, 3'b000};
        return sh[7:0];
    endfunction

    // Saturating increment of the back-to-back frame counter.
    function automatic logic [7:0] burst_inc(input logic [7:0] b);
        logic [7:0] r;
        if (b >= BURST_SAT) begin
            r = BURST_SAT;
        end else begin
            r = b + 8'd1;
        end
        return r;
    endfunction

    // Word acceptance: only at a frame boundary, never with a resync waiting,
    // and not when this EOF closes the last frame allowed in a burst.
    always_comb begin
        ready = 1'b0;
        case (state)
            ST_IDLE: ready = !resync_pend;
            ST_EOF:  ready = !resync_pend && (({1'b0, burst_cnt} + 9'd1) < BURST_LIM);
            default: ready = 1'b0;
        endcase
    end

    assign s_axis.s_ready = ready;
    assign handshake      = s_axis.s_valid && ready;

    // Sequencer: state, counters, captured word and the registered symbol
    // presented to the encoder (always the symbol of the state being entered).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_TRAIN;
            train_cnt   <= 8'd0;
            burst_cnt   <= 8'd0;
            resync_pend <= 1'b0;
            idx         <= IDX_ZERO;
            word        <= {LOGIC_SIZE{1'b0}};
            o_byte      <= K_COMMA;
            o_kin       <= 1'b1;
            o_en        <= 1'b0;
            o_trained   <= 1'b0;
        end else begin
            o_en <= 1'b1;
            // A request is remembered until the next frame boundary.
            if (i_resync) begin
                resync_pend <= 1'b1;
            end
            case (state)
                ST_TRAIN: begin
                    // A request while training just restarts the count.
                    resync_pend <= 1'b0;
                    o_byte      <= K_COMMA;
                    o_kin       <= 1'b1;
                    if (i_resync) begin
                        train_cnt <= 8'd0;
                    end else if (o_en) begin
                        // Only commas seen by an enabled encoder are counted.
                        if (train_cnt == TRAIN_LAST) begin
                            state     <= ST_IDLE;
                            train_cnt <= 8'd0;
                            o_trained <= 1'b1;
                        end else begin
                            train_cnt <= train_cnt + 8'd1;
                        end
                    end
                end

                ST_IDLE: begin
                    burst_cnt <= 8'd0;
                    if (handshake) begin
                        state  <= ST_SOF;
                        word   <= s_axis.s_tdata;
                        o_byte <= K_SOF;
                        o_kin  <= 1'b1;
                    end else if (resync_pend) begin
                        state       <= ST_TRAIN;
                        train_cnt   <= 8'd0;
                        resync_pend <= 1'b0;
                        o_trained   <= 1'b0;
                        o_byte      <= K_COMMA;
                        o_kin       <= 1'b1;
                    end else begin
                        o_byte <= K_COMMA;
                        o_kin  <= 1'b1;
                    end
                end

                ST_SOF: begin
                    state  <= ST_DATA;
                    idx    <= IDX_ZERO;
                    o_byte <= word_byte(word, IDX_ZERO);
                    o_kin  <= 1'b0;
                end

                ST_DATA: begin
                    if (idx == IDX_LAST) begin
                        state  <= ST_EOF;
                        o_byte <= K_EOF;
                        o_kin  <= 1'b1;
                    end else begin
                        idx    <= idx + IDX_ONE;
                        o_byte <= word_byte(word, idx + IDX_ONE);
                        o_kin  <= 1'b0;
                    end
                end

                ST_EOF: begin
                    burst_cnt <= burst_inc(burst_cnt);
                    if (handshake) begin
                        state  <= ST_SOF;
                        word   <= s_axis.s_tdata;
                        o_byte <= K_SOF;
                        o_kin  <= 1'b1;
                    end else if (resync_pend) begin
                        state       <= ST_TRAIN;
                        train_cnt   <= 8'd0;
                        resync_pend <= 1'b0;
                        o_trained   <= 1'b0;
                        o_byte      <= K_COMMA;
                        o_kin       <= 1'b1;
                    end else begin
                        state  <= ST_IDLE;
                        o_byte <= K_COMMA;
                        o_kin  <= 1'b1;
                    end
                end

                default: begin
                    // Unreachable encoding: recover through a full comma train.
                    state       <= ST_TRAIN;
                    train_cnt   <= 8'd0;
                    resync_pend <= 1'b0;
                    o_trained   <= 1'b0;
                    o_byte      <= K_COMMA;
                    o_kin       <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serdes_tx_ctrl.sv
// Self-checking bench for serdes_tx_ctrl: directed scenarios followed by a
// randomized phase, all compared cycle by cycle against a symbol-stream model.
module tb_serdes_tx_ctrl;
    localparam int LOGIC_SIZE = 32;
    localparam int NBYTES     = LOGIC_SIZE / 8;
    localparam int TRAIN_LEN  = 16;
    localparam int MAX_BURST  = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_resync;
    logic [7:0] o_byte;
    logic       o_kin;
    logic       o_en;
    logic       o_trained;

    serdes_tx_ctrl_if #(.LOGIC_SIZE(LOGIC_SIZE)) axis ();

    serdes_tx_ctrl #(
        .LOGIC_SIZE(LOGIC_SIZE),
        .TRAIN_LEN (TRAIN_LEN),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_axis   (axis),
        .i_resync (i_resync),
        .o_byte   (o_byte),
        .o_kin    (o_kin),
        .o_en     (o_en),
        .o_trained(o_trained)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: the expected symbol stream. During a frame the remaining symbols
    // sit in a queue; outside a frame the link shows commas (training or idle).
    bit         m_training;
    bit         m_en;
    bit         m_in_frame;
    bit         m_pend;
    int         m_done;
    int         m_burst;
    logic [8:0] m_sym;
    logic [8:0] m_q[$];
    bit         last_hs;

    logic [9:0] obs_log[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_training = 1'b1;
        m_en       = 1'b0;
        m_in_frame = 1'b0;
        m_pend     = 1'b0;
        m_done     = 0;
        m_burst    = 0;
        m_sym      = 9'h1BC;
        m_q.delete();
    endtask

    function automatic bit model_ready();
        return !m_training && !m_pend &&
               (!m_in_frame || (m_q.size() == 0 && m_burst + 1 < MAX_BURST));
    endfunction

    task automatic model_edge(input bit v, input logic [31:0] d, input bit rs, input bit rdy);
        bit hs;
        bit old_pend;
        hs      = v && rdy;
        last_hs = hs;
        if (m_training) begin
            if (!m_en) begin
                m_en   = 1'b1;
                m_done = 1;
            end else if (rs) begin
                m_done = 1;
            end else if (m_done == TRAIN_LEN) begin
                m_training = 1'b0;
            end else begin
                m_done++;
            end
        end else if (m_in_frame && m_q.size() > 0) begin
            m_sym = m_q.pop_front();
            if (rs) m_pend = 1'b1;
        end else begin
            old_pend = m_pend;
            if (rs) m_pend = 1'b1;
            if (m_in_frame) m_burst = (m_burst + 1 > MAX_BURST) ? MAX_BURST : m_burst + 1;
            else            m_burst = 0;
            if (hs) begin
                m_in_frame = 1'b1;
                m_sym      = 9'h1FB;
                for (int b = 0; b < NBYTES; b++) m_q.push_back({1'b0, d[8*b +: 8]});
                m_q.push_back(9'h1FD);
            end else if (old_pend) begin
                m_training = 1'b1;
                m_done     = 1;
                m_pend     = 1'b0;
                m_in_frame = 1'b0;
                m_sym      = 9'h1BC;
            end else begin
                m_in_frame = 1'b0;
                m_sym      = 9'h1BC;
            end
        end
    endtask

    // One clock: drive inputs at the falling edge, check s_ready before the
    // rising edge, advance the model, check registered outputs at next fall.
    task automatic step(input bit v, input logic [31:0] d, input bit rs);
        bit rdy;
        axis.s_valid = v;
        axis.s_tdata = d;
        i_resync     = rs;
        #1;
        rdy = model_ready();
        check("s_ready", {31'd0, axis.s_ready}, {31'd0, rdy});
        @(posedge clk);
        model_edge(v, d, rs, rdy);
        @(negedge clk);
        check("o_byte",    {24'd0, o_byte},    {24'd0, m_sym[7:0]});
        check("o_kin",     {31'd0, o_kin},     {31'd0, m_sym[8]});
        check("o_en",      {31'd0, o_en},      {31'd0, m_en});
        check("o_trained", {31'd0, o_trained}, {31'd0, !m_training});
        obs_log.push_back({o_trained, o_kin, o_byte});
    endtask

    task automatic settle();
        int n;
        n = 0;
        while ((m_training || m_in_frame) && n < 60) begin
            step(1'b0, $urandom, 1'b0);
            n++;
        end
        check("settle", {30'd0, m_training, m_in_frame}, 32'd0);
    endtask

    function automatic int first_trained();
        for (int i = 0; i < obs_log.size(); i++) begin
            if (obs_log[i][9]) return i + 1;
        end
        return -1;
    endfunction

    function automatic int count_untrained();
        int c;
        c = 0;
        for (int i = 0; i < obs_log.size(); i++) begin
            if (!obs_log[i][9]) c++;
        end
        return c;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [8:0]  exp_seq[7];
        logic [31:0] words[10];
        int          k;
        int          n;
        int          first_sof;
        int          last_eof;
        int          commas;
        int          sofs;
        int          eof_at;

        exp_seq = '{9'h1FB, 9'h0EF, 9'h0BE, 9'h0AD, 9'h0DE, 9'h1FD, 9'h1BC};

        // Reset state
        rst          = 1'b1;
        axis.s_valid = 1'b0;
        axis.s_tdata = 32'd0;
        i_resync     = 1'b0;
        #3;
        check("rst_byte",    {24'd0, o_byte},       32'h0BC);
        check("rst_kin",     {31'd0, o_kin},        32'd1);
        check("rst_en",      {31'd0, o_en},         32'd0);
        check("rst_trained", {31'd0, o_trained},    32'd0);
        check("rst_ready",   {31'd0, axis.s_ready}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();

        // 1: training length after reset release
        obs_log.delete();
        repeat (20) step(1'b0, 32'd0, 1'b0);
        check("train_first_trained", 32'(first_trained()), 32'(TRAIN_LEN + 1));

        // 2: single word framing
        obs_log.delete();
        step(1'b1, 32'hDEADBEEF, 1'b0);
        repeat (7) step(1'b0, $urandom, 1'b0);
        for (int i = 0; i < 7; i++) check("frame_seq", {23'd0, obs_log[i][8:0]}, {23'd0, exp_seq[i]});

        // 3: continuous valid, ten words, burst limit forces one comma
        for (int i = 0; i < 10; i++) words[i] = 32'(i + 1);
        obs_log.delete();
        k = 0;
        n = 0;
        while (k < 10 && n < 200) begin
            step(1'b1, words[k], 1'b0);
            if (last_hs) k++;
            n++;
        end
        check("burst_all_accepted", 32'(k), 32'd10);
        repeat (8) step(1'b0, 32'd0, 1'b0);
        first_sof = -1;
        last_eof  = -1;
        sofs      = 0;
        for (int i = 0; i < obs_log.size(); i++) begin
            if (obs_log[i][8:0] == 9'h1FB) begin
                sofs++;
                if (first_sof < 0) first_sof = i;
            end
            if (obs_log[i][8:0] == 9'h1FD) last_eof = i;
        end
        commas = 0;
        for (int i = first_sof; i >= 0 && i <= last_eof; i++) begin
            if (obs_log[i][8:0] == 9'h1BC) commas++;
        end
        check("burst_sof_count", 32'(sofs), 32'd10);
        check("burst_span", 32'(last_eof - first_sof + 1), 32'(10 * (NBYTES + 2) + 1));
        check("burst_gap_commas", 32'(commas), 32'd1);

        // 4: resync during data byte 1 finishes the frame, then trains
        settle();
        obs_log.delete();
        step(1'b1, 32'h11223344, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        repeat (30) step(1'b0, 32'h0, 1'b0);
        check("resync_eof", {23'd0, obs_log[NBYTES + 1][8:0]}, 32'h1FD);
        check("resync_train_len", 32'(count_untrained()), 32'(TRAIN_LEN));
        check("resync_after_eof", {31'd0, obs_log[NBYTES + 2][9]}, 32'd0);

        // 5: valid and resync on the same idle edge
        settle();
        obs_log.delete();
        step(1'b1, 32'hCAFEF00D, 1'b1);
        repeat (30) step(1'b0, $urandom, 1'b0);
        eof_at = -1;
        for (int i = 0; i < obs_log.size(); i++) begin
            if (eof_at < 0 && obs_log[i][8:0] == 9'h1FD) eof_at = i;
        end
        check("same_edge_eof_pos", 32'(eof_at), 32'(NBYTES + 1));
        check("same_edge_train_len", 32'(count_untrained()), 32'(TRAIN_LEN));

        // 6: reset during data byte 2
        settle();
        step(1'b1, 32'h55667788, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("midrst_byte",    {24'd0, o_byte},       32'h0BC);
        check("midrst_kin",     {31'd0, o_kin},        32'd1);
        check("midrst_en",      {31'd0, o_en},         32'd0);
        check("midrst_ready",   {31'd0, axis.s_ready}, 32'd0);
        check("midrst_trained", {31'd0, o_trained},    32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        obs_log.delete();
        repeat (20) step(1'b0, 32'h0, 1'b0);
        check("midrst_first_trained", 32'(first_trained()), 32'(TRAIN_LEN + 1));

        // Randomized traffic with occasional resync requests
        repeat (600) begin
            step($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 49) == 0);
        end
        settle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
